sonic_gearbox_ring_buffer: RTL and testbench
============================================

Name: sonic_gearbox_ring_buffer

Overview:
- Single-clock, parametrised circular buffer with width gearbox. Accepts IN_W-bit words and delivers RATIO packed words (IN_W*RATIO bits) per read.
- Successor to the fixed-width sonic circular buffer in the SONIC datapath: sits between the PCS-side word stream and the 128-bit DMA-side consumer.
- Adds programmable almost thresholds, an optional overwrite-oldest mode, synchronous flush, a fill-level output and error pulses.

Parameters:
- IN_W, 32: input word width in bits.
- RATIO, 4: input words packed per output read. Output width is IN_W*RATIO (default 128).
- DEPTH, 64: capacity in input words. Must be a power of two and ≥ 2*RATIO.
- AFULL_THR, 56: almost_full asserts when level ≥ AFULL_THR.
- AEMPTY_THR, 8: almost_empty asserts when level ≤ AEMPTY_THR.
- LW = $clog2(DEPTH)+1: derived level width.

Ports:
- clk, in, 1: single clock for all logic.
- reset_n, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous clear of contents.
- overwrite_en, in, 1: 1 = a write when full discards the oldest word; 0 = a write when full is dropped.
- wr_en, in, 1: write request.
- wr_data, in, IN_W: write word.
- rd_en, in, 1: read request for RATIO words.
- rd_data, out, IN_W*RATIO: packed read data, registered.
- rd_valid, out, 1: rd_data is valid this cycle.
- empty, out, 1: level < RATIO, i.e. no full output group available.
- full, out, 1: level == DEPTH.
- almost_full, out, 1: level ≥ AFULL_THR.
- almost_empty, out, 1: level ≤ AEMPTY_THR.
- level, out, LW: number of stored input words.
- overflow, out, 1: one-cycle pulse when a write is dropped.
- overwrote, out, 1: one-cycle pulse when the oldest word is discarded.
- underflow, out, 1: one-cycle pulse when rd_en arrives while empty.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr, rd_ptr, level = 0; rd_data = 0; rd_valid = 0; overflow/overwrote/underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Storage contents are don't-care.
- Storage: DEPTH x IN_W flop array. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Status outputs (empty, full, almost_*) are combinational from the registered level.
- Priority each cycle: flush > read/write.
- Flush: pointers and level go to 0 next edge; rd_valid = 0 next cycle; error pulses are 0. wr_en and rd_en are ignored in that cycle.
- Read accepted when rd_en && !empty:
  - Next cycle: rd_data[k*IN_W +: IN_W] = mem[rd_ptr+k] for k = 0..RATIO-1, with the oldest word in the LSBs; rd_valid = 1.
  - rd_ptr += RATIO (mod DEPTH).
  - Latency is 1 cycle. rd_data holds its value when no read is accepted; rd_valid = 0 in those cycles.
- rd_en && empty: no state change; underflow pulses next cycle; rd_valid = 0.
- Write when !full: mem[wr_ptr] = wr_data; wr_ptr += 1.
- Write when full and a read is accepted the same cycle: the write proceeds normally; no overflow, no overwrite.
- Write when full with no accepted read, overwrite_en = 0: write dropped; overflow pulses; no state change.
- Write when full with no accepted read, overwrite_en = 1: write stored; wr_ptr += 1; rd_ptr += 1; level stays DEPTH; overwrote pulses.
- Level update: level_next = level + wr_acc - RATIO*rd_acc, minus 0 in the overwrite case. It never exceeds DEPTH and never goes below 0.
- Simultaneous read and write: the read uses pre-write contents. The written word becomes visible to a read starting next cycle.
- reset_n asserted mid-operation: immediate return to reset state. An in-flight rd_valid is cancelled.

Decomposition:
- Package sonic_buffer_pkg holds:
  - function clog2_depth;
  - typedef enum {BUF_DROP, BUF_OVERWRITE} buf_mode_e, used by the bench to drive overwrite_en;
  - default constants for IN_W, RATIO and DEPTH.
- One sub-module: sonic_ring_ptr_ctrl. It takes wr_acc, rd_acc, overwrite and flush, and produces wr_ptr, rd_ptr and level. The top module holds the storage, packing mux and output registers.

Test Plan:
1. Release reset_n after 100 ns → level = 0, empty = 1, almost_empty = 1, rd_valid = 0. A read in this state pulses underflow once.
2. Write 0..7, then rd_en for two cycles → rd_data = {3,2,1,0} then {7,6,5,4}, each with rd_valid one cycle after rd_en; level ends at 0, empty = 1.
3. overwrite_en = 0, write 0..63 → full = 1, almost_full asserted from level 56. Write 0xDEAD → overflow pulse, level = 64. First read returns {3,2,1,0}.
4. overwrite_en = 1, buffer full with 0..63, write 0xBEEF → overwrote pulse, level = 64. Next read returns {4,3,2,1}; the last group read contains 0xBEEF in its MSBs.
5. Level = 4, simultaneous rd_en and wr_en(0x55) → level = 1, rd_data holds the old 4 words. Full with simultaneous rd+wr → no overflow, level = 61.
6. Flush at level 20 with rd_en high → level = 0 and rd_valid = 0 next cycle. reset_n pulsed low mid-read → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sonic_buffer_pkg.sv
// Shared types and defaults for the sonic gearbox ring buffer.
package sonic_buffer_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_RATIO = 4;
  localparam int DEF_DEPTH = 64;

  // Behaviour of a write that arrives while the buffer is full.
  typedef enum logic {
    BUF_DROP      = 1'b0,
    BUF_OVERWRITE = 1'b1
  } buf_mode_e;

  function automatic int clog2_depth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sonic_ring_ptr_ctrl.sv
// Pointer and fill-level bookkeeping for the gearbox ring buffer.
// rd_acc and overwrite are mutually exclusive by construction in the top.
module sonic_ring_ptr_ctrl
  import sonic_buffer_pkg::*;
#(
  parameter  int RATIO = DEF_RATIO,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = clog2_depth(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          wr_acc,
  input  logic          rd_acc,
  input  logic          overwrite,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [LW-1:0] level
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Next pointers/level; overwrite advances both pointers and keeps level at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc || overwrite) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc)              rd_ptr_d = rd_ptr_q + PW'(RATIO);
      else if (overwrite)      rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(wr_acc) - (rd_acc ? LW'(RATIO) : LW'(0));
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign level  = level_q;

endmodule

// File: rtl/sonic_gearbox_ring_buffer.sv
// Circular buffer taking IN_W-bit words and returning RATIO packed words per read.
// Oldest word of a group lands in the LSBs of rd_data.
module sonic_gearbox_ring_buffer
  import sonic_buffer_pkg::*;
#(
  parameter  int IN_W       = DEF_IN_W,
  parameter  int RATIO      = DEF_RATIO,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int AFULL_THR  = 56,
  parameter  int AEMPTY_THR = 8,
  localparam int PW         = clog2_depth(DEPTH),
  localparam int LW         = PW + 1,
  localparam int OW         = IN_W * RATIO
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            overwrite_en,
  input  logic            wr_en,
  input  logic [IN_W-1:0] wr_data,
  input  logic            rd_en,
  output logic [OW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            empty,
  output logic            full,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [LW-1:0]   level,
  output logic            overflow,
  output logic            overwrote,
  output logic            underflow
);

  logic [IN_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            rd_acc, wr_acc, ovw, drop, under;
  logic [OW-1:0]   rd_pack;
  logic [OW-1:0]   rd_data_q;
  logic            rd_valid_q, overflow_q, overwrote_q, underflow_q;

  assign empty        = level < LW'(RATIO);
  assign full         = level == LW'(DEPTH);
  assign almost_full  = level >= LW'(AFULL_THR);
  assign almost_empty = level <= LW'(AEMPTY_THR);

  // Accept decisions; flush masks every request in its cycle.
  always_comb begin
    rd_acc = !flush && rd_en && !empty;
    under  = !flush && rd_en && empty;
    wr_acc = !flush && wr_en && (!full || rd_acc);
    ovw    = !flush && wr_en && full && !rd_acc && overwrite_en;
    drop   = !flush && wr_en && full && !rd_acc && !overwrite_en;
  end

  sonic_ring_ptr_ctrl #(
    .RATIO (RATIO),
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .wr_acc    (wr_acc),
    .rd_acc    (rd_acc),
    .overwrite (ovw),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .level     (level)
  );

  // Storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_acc || ovw) mem_q[wr_ptr] <= wr_data;
  end

  // Gather RATIO consecutive words starting at rd_ptr (pre-write contents).
  always_comb begin
    rd_pack = '0;
    for (int k = 0; k < RATIO; k++) begin
      rd_pack[k*IN_W +: IN_W] = mem_q[rd_ptr + PW'(k)];
    end
  end

  // Registered read data, valid strobe and error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      overwrote_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (rd_acc) rd_data_q <= rd_pack;
      rd_valid_q  <= rd_acc;
      overflow_q  <= drop;
      overwrote_q <= ovw;
      underflow_q <= under;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign overwrote = overwrote_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sonic_gearbox_ring_buffer.sv
// Directed bench for the gearbox ring buffer with a read-data scoreboard.
module tb_sonic_gearbox_ring_buffer;
  import sonic_buffer_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         overwrite_en;
  logic         wr_en;
  logic [31:0]  wr_data;
  logic         rd_en;
  logic [127:0] rd_data;
  logic         rd_valid, empty, full, almost_full, almost_empty;
  logic [6:0]   level;
  logic         overflow, overwrote, underflow;
  buf_mode_e    mode;

  int errors = 0;
  int checks = 0;
  logic [127:0] expq [$];

  assign overwrite_en = (mode == BUF_OVERWRITE);

  sonic_gearbox_ring_buffer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .overwrite_en (overwrite_en),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .overwrote    (overwrote),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pk(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] wd, input logic re, input logic fl);
    @(negedge clk);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    flush   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [127:0] exp);
    expq.push_back(exp);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  // Scoreboard monitor: every presented read group must match the oldest expectation.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && rd_valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %0h required no read", rd_data);
        end else begin
          e = expq.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL sb_rd_data: got %0h required %0h", rd_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [64];
    reset_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    mode = BUF_DROP;
    #100 reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset state and underflow
    chk("rst_level", 128'(level), 128'd0);
    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_aempty", 128'(almost_empty), 128'd1);
    chk("rst_full", 128'(full), 128'd0);
    chk("rst_afull", 128'(almost_full), 128'd0);
    chk("rst_valid", 128'(rd_valid), 128'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("underflow_pulse", 128'(underflow), 128'd1);
    chk("underflow_nvalid", 128'(rd_valid), 128'd0);
    idle();
    chk("underflow_clear", 128'(underflow), 128'd0);

    // 2: basic packing
    for (int i = 0; i < 8; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    chk("t2_level8", 128'(level), 128'd8);
    chk("t2_aempty8", 128'(almost_empty), 128'd1);
    rd(pk(0, 1, 2, 3));
    chk("t2_valid", 128'(rd_valid), 128'd1);
    rd(pk(4, 5, 6, 7));
    idle();
    chk("t2_valid_drop", 128'(rd_valid), 128'd0);
    chk("t2_hold", rd_data, pk(4, 5, 6, 7));
    chk("t2_level0", 128'(level), 128'd0);
    chk("t2_empty", 128'(empty), 128'd1);

    // 3: fill, drop on full
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 54) chk("t3_afull55", 128'(almost_full), 128'd0);
      if (i == 55) chk("t3_afull56", 128'(almost_full), 128'd1);
    end
    chk("t3_full", 128'(full), 128'd1);
    drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("t3_overflow", 128'(overflow), 128'd1);
    chk("t3_no_ovw", 128'(overwrote), 128'd0);
    chk("t3_level", 128'(level), 128'd64);
    idle();
    chk("t3_overflow_clear", 128'(overflow), 128'd0);
    rd(pk(0, 1, 2, 3));
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t3_flush_level", 128'(level), 128'd0);

    // 4: overwrite oldest
    mode = BUF_OVERWRITE;
    for (int i = 0; i < 64; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'hBEEF, 1'b0, 1'b0);
    chk("t4_overwrote", 128'(overwrote), 128'd1);
    chk("t4_no_overflow", 128'(overflow), 128'd0);
    chk("t4_level", 128'(level), 128'd64);
    for (int i = 0; i < 63; i++) w[i] = 32'(i + 1);
    w[63] = 32'hBEEF;
    for (int g = 0; g < 16; g++) rd(pk(w[4*g], w[4*g+1], w[4*g+2], w[4*g+3]));
    idle();
    chk("t4_level0", 128'(level), 128'd0);
    chk("t4_last_msb", 128'(rd_data[127:96]), 128'hBEEF);
    mode = BUF_DROP;

    // 5: simultaneous read and write
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(10 + i), 1'b0, 1'b0);
    expq.push_back(pk(10, 11, 12, 13));
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    chk("t5_level1", 128'(level), 128'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h56 + 32'(i), 1'b0, 1'b0);
    rd(pk(32'h55, 32'h56, 32'h57, 32'h58));
    idle();
    for (int i = 0; i < 64; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    expq.push_back(pk(0, 1, 2, 3));
    drive(1'b1, 32'h77, 1'b1, 1'b0);
    chk("t5_full_no_overflow", 128'(overflow), 128'd0);
    chk("t5_level61", 128'(level), 128'd61);
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    // 6: flush with read pending, then async reset mid-read
    for (int i = 0; i < 20; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    chk("t6_aempty20", 128'(almost_empty), 128'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t6_flush_level", 128'(level), 128'd0);
    chk("t6_flush_valid", 128'(rd_valid), 128'd0);
    chk("t6_flush_underflow", 128'(underflow), 128'd0);
    idle();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'(100 + i), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_inflight_valid", 128'(rd_valid), 128'd1);
    chk("t6_inflight_data", rd_data, pk(100, 101, 102, 103));
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 128'(rd_valid), 128'd0);
    chk("t6_rst_data", rd_data, 128'd0);
    chk("t6_rst_level", 128'(level), 128'd0);
    chk("t6_rst_empty", 128'(empty), 128'd1);
    chk("t6_rst_aempty", 128'(almost_empty), 128'd1);
    chk("t6_rst_full", 128'(full), 128'd0);
    rd_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    idle();
    chk("sb_drain", 128'(expq.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
